// File: rtl/asteroids_rom_loader.sv
// ROM download tracker between hps_io's ioctl port and ASTEROIDS_TOP's dn_* write port.
// Optional build macro ASTEROIDS_ROM_CHECKSUM_EN adds an 8-bit additive checksum to the verify step.
module asteroids_rom_loader #(
  parameter logic [15:0] ROM_SIZE        = 16'h2000,
  parameter logic [15:0] VEC_BASE        = 16'h1800,
`ifdef ASTEROIDS_ROM_CHECKSUM_EN
  parameter logic [7:0]  CHECKSUM_EXPECT = 8'h00,
`endif
  parameter int unsigned RESET_HOLD      = 16
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        prog_we,
  output logic        vec_we,
  output logic        core_reset,
  output logic        rom_ready,
  output logic        rom_error,
  output logic [15:0] bytes_loaded
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_VERIFY = 3'd2;
  localparam logic [2:0] ST_READY  = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam logic [15:0] HOLD_INIT = 16'(RESET_HOLD);

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic        dl_prev_r;
  logic [15:0] hold_r;
  logic [15:0] hold_s;
  logic        ovf_r;
  logic        dl_rise_s;
  logic        dl_fall_s;
  logic        in_range_s;
  logic        accept_s;
  logic        oob_s;
  logic        is_prog_s;
  logic        core_reset_s;
  logic        csum_ok_s;

  // Download edge detection, write qualification and next-state decode
  always_comb begin
    dl_rise_s  = ioctl_download & ~dl_prev_r;
    dl_fall_s  = ~ioctl_download & dl_prev_r;
    in_range_s = (ioctl_addr < {9'd0, ROM_SIZE});
    accept_s   = (state_r == ST_LOAD) & ioctl_wr & in_range_s;
    oob_s      = (state_r == ST_LOAD) & ioctl_wr & ~in_range_s;
    is_prog_s  = (ioctl_addr[15:0] < VEC_BASE);
    state_s    = state_r;
    if (dl_rise_s) begin
      state_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE:   state_s = ST_IDLE;
        ST_LOAD:   state_s = dl_fall_s ? ST_VERIFY : ST_LOAD;
        ST_VERIFY: begin
          if ((bytes_loaded == ROM_SIZE) && !ovf_r && csum_ok_s) begin
            state_s = ST_READY;
          end else begin
            state_s = ST_ERROR;
          end
        end
        ST_READY:  state_s = ST_READY;
        ST_ERROR:  state_s = ST_ERROR;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Post-load hold counter and the resulting core reset level
  always_comb begin
    hold_s = HOLD_INIT;
    if (state_s == ST_READY) begin
      if (state_r != ST_READY) begin
        hold_s = HOLD_INIT;
      end else if (hold_r != 16'd0) begin
        hold_s = hold_r - 16'd1;
      end else begin
        hold_s = 16'd0;
      end
    end else begin
      hold_s = HOLD_INIT;
    end
    if (state_s == ST_READY) begin
      core_reset_s = user_reset | (hold_s != 16'd0);
    end else begin
      core_reset_s = 1'b1;
    end
  end

`ifdef ASTEROIDS_ROM_CHECKSUM_EN
  logic [7:0] csum_r;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

  // Running 8-bit sum of accepted bytes, restarted by each new download
  always_ff @(posedge clk_25) begin
    if (reset) begin
      csum_r <= 8'h00;
    end else if (dl_rise_s) begin
      csum_r <= 8'h00;
    end else if (accept_s) begin
      csum_r <= csum_add(csum_r, ioctl_dout);
    end else begin
      csum_r <= csum_r;
    end
  end

  assign csum_ok_s = (csum_r == CHECKSUM_EXPECT);
`else
  assign csum_ok_s = 1'b1;
`endif

  // State, write path and status registers
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      // A download already in flight at reset must not look like a fresh start
      dl_prev_r    <= 1'b1;
      hold_r       <= HOLD_INIT;
      ovf_r        <= 1'b0;
      dn_addr      <= 16'h0000;
      dn_data      <= 8'h00;
      dn_wr        <= 1'b0;
      prog_we      <= 1'b0;
      vec_we       <= 1'b0;
      core_reset   <= 1'b1;
      rom_ready    <= 1'b0;
      rom_error    <= 1'b0;
      bytes_loaded <= 16'h0000;
    end else begin
      state_r    <= state_s;
      dl_prev_r  <= ioctl_download;
      hold_r     <= hold_s;
      dn_wr      <= accept_s;
      prog_we    <= accept_s & is_prog_s;
      vec_we     <= accept_s & ~is_prog_s;
      core_reset <= core_reset_s;
      rom_ready  <= (state_s == ST_READY);
      rom_error  <= (state_s == ST_ERROR);
      if (accept_s) begin
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
      end else begin
        dn_addr <= dn_addr;
        dn_data <= dn_data;
      end
      if (dl_rise_s) begin
        bytes_loaded <= 16'h0000;
        ovf_r        <= 1'b0;
      end else begin
        if (accept_s && (bytes_loaded != 16'hFFFF)) begin
          bytes_loaded <= bytes_loaded + 16'd1;
        end else begin
          bytes_loaded <= bytes_loaded;
        end
        ovf_r <= ovf_r | oob_s;
      end
    end
  end

endmodule

// File: tb/tb_asteroids_rom_loader.sv
// Randomized self-checking bench for asteroids_rom_loader against an image-level reference model.
module tb_asteroids_rom_loader;

  localparam logic [15:0] ROM_SIZE   = 16'h2000;
  localparam logic [15:0] VEC_BASE   = 16'h1800;
  localparam int          RESET_HOLD = 16;

  logic        clk_25 = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        user_reset = 1'b0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        prog_we;
  logic        vec_we;
  logic        core_reset;
  logic        rom_ready;
  logic        rom_error;
  logic [15:0] bytes_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  logic [24:0] img_addr[$];
  logic [7:0]  img_data[$];

  asteroids_rom_loader dut (
    .clk_25        (clk_25),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .user_reset    (user_reset),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .prog_we       (prog_we),
    .vec_we        (vec_we),
    .core_reset    (core_reset),
    .rom_ready     (rom_ready),
    .rom_error     (rom_error),
    .bytes_loaded  (bytes_loaded)
  );

  always #20 clk_25 = ~clk_25;

  function automatic void build_image(input int count, input bit rand_data);
    img_addr.delete();
    img_data.delete();
    for (int i = 0; i < count; i++) begin
      img_addr.push_back(25'(i));
      img_data.push_back(rand_data ? 8'($urandom) : 8'(i));
    end
  endfunction

  // Plays the image through ioctl, checks every write slot and the final verdict
  task automatic download(input bit coincident);
    int n = img_addr.size();
    int exp_cnt = 0, exp_prog = 0, exp_vec = 0;
    bit exp_ovf = 1'b0;
    bit exp_ready;
    logic [7:0] exp_sum = 8'h00;
    int bad = 0, nwr = 0, nprog = 0, nvec = 0, waited = 0;
    string bad_msg = "";
    bit hit, isprog;
    for (int i = 0; i < n; i++) begin
      if (img_addr[i] < 25'(ROM_SIZE)) begin
        exp_cnt++;
        exp_sum += img_data[i];
        if (img_addr[i] < 25'(VEC_BASE)) exp_prog++; else exp_vec++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    exp_ready = (exp_cnt == int'(ROM_SIZE)) && !exp_ovf;
`ifdef ASTEROIDS_ROM_CHECKSUM_EN
    exp_ready = exp_ready && (exp_sum == 8'h00);
`endif
    @(negedge clk_25);
    ioctl_download = 1'b1;
    @(posedge clk_25);
    @(negedge clk_25);
    n_checks++;
    if ({rom_ready, rom_error, core_reset} !== 3'b001 || bytes_loaded !== 16'h0000) begin
      $display("FAIL dl_start: ready/error/core_reset=%b bytes=%0h, required 001 bytes=0",
               {rom_ready, rom_error, core_reset}, bytes_loaded);
    end else n_pass++;
    for (int i = 0; i < n; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = img_addr[i];
      ioctl_dout = img_data[i];
      if (coincident && i == n - 1) ioctl_download = 1'b0;
      @(posedge clk_25);
      @(negedge clk_25);
      hit    = img_addr[i] < 25'(ROM_SIZE);
      isprog = img_addr[i] < 25'(VEC_BASE);
      if (dn_wr !== hit || prog_we !== (hit && isprog) || vec_we !== (hit && !isprog) ||
          (hit && (dn_addr !== img_addr[i][15:0] || dn_data !== img_data[i]))) begin
        if (bad == 0) bad_msg = $sformatf("at ioctl_addr %0h dn_wr=%b dn_addr=%0h dn_data=%0h prog=%b vec=%b",
                                          img_addr[i], dn_wr, dn_addr, dn_data, prog_we, vec_we);
        bad++;
      end
      if (dn_wr === 1'b1) nwr++;
      if (prog_we === 1'b1) nprog++;
      if (vec_we === 1'b1) nvec++;
      ioctl_wr = 1'b0;
      if (i != n - 1 && $urandom_range(0, 7) == 0) begin
        @(posedge clk_25);
        @(negedge clk_25);
        if (dn_wr !== 1'b0 || prog_we !== 1'b0 || vec_we !== 1'b0) begin
          if (bad == 0) bad_msg = $sformatf("idle slot after %0h dn_wr=%b", img_addr[i], dn_wr);
          bad++;
        end
      end
    end
    if (!coincident) ioctl_download = 1'b0;
    while (!(rom_ready === 1'b1 || rom_error === 1'b1) && waited < 8) begin
      @(posedge clk_25);
      @(negedge clk_25);
      waited++;
    end
    n_checks++;
    if (waited >= 8) $display("FAIL verdict_timeout: waited %0d cycles, required < 8", waited);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL write_stream: %0d bad slots, first %s, required 0", bad, bad_msg);
    else n_pass++;
    n_checks++;
    if (nwr !== exp_cnt || nprog !== exp_prog || nvec !== exp_vec)
      $display("FAIL write_counts: dn_wr/prog/vec=%0d/%0d/%0d, required %0d/%0d/%0d",
               nwr, nprog, nvec, exp_cnt, exp_prog, exp_vec);
    else n_pass++;
    n_checks++;
    if (bytes_loaded !== 16'(exp_cnt)) $display("FAIL bytes_loaded: got %0h, required %0h", bytes_loaded, exp_cnt);
    else n_pass++;
    n_checks++;
    if (rom_ready !== exp_ready || rom_error !== !exp_ready || core_reset !== 1'b1)
      $display("FAIL verdict: ready=%b error=%b core_reset=%b, required ready=%b error=%b core_reset=1",
               rom_ready, rom_error, core_reset, exp_ready, !exp_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_25);
    @(negedge clk_25);
    n_checks++;
    if (dn_addr !== 16'h0000 || dn_data !== 8'h00 || {dn_wr, prog_we, vec_we} !== 3'b000 ||
        {core_reset, rom_ready, rom_error} !== 3'b100 || bytes_loaded !== 16'h0000)
      $display("FAIL reset_state: addr=%0h data=%0h wr/p/v=%b cr/rdy/err=%b bytes=%0h, required 0 0 000 100 0",
               dn_addr, dn_data, {dn_wr, prog_we, vec_we}, {core_reset, rom_ready, rom_error}, bytes_loaded);
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(posedge clk_25);
    @(negedge clk_25);
    n_checks++;
    if ({core_reset, rom_ready, rom_error} !== 3'b100)
      $display("FAIL idle_after_reset: cr/rdy/err=%b, required 100", {core_reset, rom_ready, rom_error});
    else n_pass++;
  endtask

  task automatic test_full_image();
    int cnt = 0;
    build_image(int'(ROM_SIZE), 1'b0);
    download(1'b0);
    while (core_reset === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk_25);
      @(negedge clk_25);
    end
    n_checks++;
    if (cnt !== RESET_HOLD) $display("FAIL reset_hold: core_reset high %0d cycles, required %0d", cnt, RESET_HOLD);
    else n_pass++;
  endtask

  task automatic test_user_reset();
    for (int k = 0; k < 3; k++) begin
      int len = $urandom_range(1, 6);
      int highs = 0;
      @(negedge clk_25);
      n_checks++;
      if (core_reset !== 1'b0) $display("FAIL user_reset_idle: core_reset=%b, required 0", core_reset);
      else n_pass++;
      user_reset = 1'b1;
      for (int j = 0; j < len; j++) begin
        @(posedge clk_25);
        @(negedge clk_25);
        if (core_reset === 1'b1) highs++;
      end
      user_reset = 1'b0;
      @(posedge clk_25);
      @(negedge clk_25);
      n_checks++;
      if (highs !== len || core_reset !== 1'b0 || rom_ready !== 1'b1)
        $display("FAIL user_reset_pulse: high %0d cycles then core_reset=%b ready=%b, required %0d then 0 1",
                 highs, core_reset, rom_ready, len);
      else n_pass++;
      repeat ($urandom_range(1, 4)) @(posedge clk_25);
    end
  endtask

  task automatic test_short_image();
    int low = 0;
    build_image(32'h1000, 1'b1);
    download(1'b0);
    repeat (20) begin
      @(posedge clk_25);
      @(negedge clk_25);
      if (core_reset !== 1'b1 || rom_error !== 1'b1) low++;
    end
    n_checks++;
    if (low !== 0) $display("FAIL error_sticky: %0d cycles left error/reset, required 0", low);
    else n_pass++;
  endtask

  task automatic test_overflow();
    build_image(int'(ROM_SIZE), 1'b0);
    img_addr.push_back(25'h2000);
    img_data.push_back(8'($urandom));
    download(1'b0);
  endtask

  task automatic test_coincident();
    build_image(int'(ROM_SIZE), 1'b0);
    download(1'b1);
  endtask

  task automatic test_reset_midload();
    int stray = 0;
    @(negedge clk_25);
    ioctl_download = 1'b1;
    @(posedge clk_25);
    @(negedge clk_25);
    for (int i = 0; i < 32'h0800; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i);
      @(posedge clk_25);
      @(negedge clk_25);
      ioctl_wr = 1'b0;
    end
    reset      = 1'b1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0800;
    @(posedge clk_25);
    @(negedge clk_25);
    reset    = 1'b0;
    ioctl_wr = 1'b0;
    n_checks++;
    if ({core_reset, rom_ready, rom_error, dn_wr} !== 4'b1000 || bytes_loaded !== 16'h0000)
      $display("FAIL midload_reset: cr/rdy/err/wr=%b bytes=%0h, required 1000 0",
               {core_reset, rom_ready, rom_error, dn_wr}, bytes_loaded);
    else n_pass++;
    for (int i = 32'h0801; i < 32'h0810; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      @(posedge clk_25);
      @(negedge clk_25);
      ioctl_wr = 1'b0;
      if (dn_wr !== 1'b0 || core_reset !== 1'b1) stray++;
    end
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk_25);
    @(negedge clk_25);
    n_checks++;
    if (stray !== 0 || {core_reset, rom_ready, rom_error} !== 3'b100)
      $display("FAIL abandoned_load: %0d stray writes, cr/rdy/err=%b, required 0 and 100",
               stray, {core_reset, rom_ready, rom_error});
    else n_pass++;
    build_image(int'(ROM_SIZE), 1'b0);
    download(1'b0);
  endtask

  task automatic test_checksum_flip();
    int idx = $urandom_range(0, int'(ROM_SIZE) - 1);
    build_image(int'(ROM_SIZE), 1'b0);
    img_data[idx] = img_data[idx] ^ 8'($urandom_range(1, 255));
    download(1'b0);
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_user_reset();
    test_short_image();
    test_overflow();
    test_coincident();
    test_reset_midload();
    test_checksum_flip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
